// File: rtl/dense_layer.sv
`timescale 1ns/1ps
// Fully-connected layer stage: z = W*a + b using a single time-multiplexed signed MAC.
// Inputs are snapshotted on start; z_out is loaded atomically on entry to DONE.
module dense_layer #(
    parameter int INPUT_WIDTH  = 3,
    parameter int OUTPUT_WIDTH = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    parameter int ACC_WIDTH    = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] a_in  [INPUT_WIDTH-1:0],
    input  logic signed [DATA_WIDTH-1:0] w_in  [OUTPUT_WIDTH*INPUT_WIDTH-1:0],
    input  logic signed [DATA_WIDTH-1:0] b_in  [OUTPUT_WIDTH-1:0],
    output logic signed [DATA_WIDTH-1:0] z_out [OUTPUT_WIDTH-1:0],
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int NW   = OUTPUT_WIDTH * INPUT_WIDTH;
    localparam int IW_B = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1;
    localparam int JW_B = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
    localparam int WW_B = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW   = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ZMAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ZMIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t                         state_reg;
    logic [IW_B-1:0]                i_reg;
    logic [JW_B-1:0]                j_reg;
    logic signed [ACC_WIDTH-1:0]    acc_reg;
    logic signed [DATA_WIDTH-1:0]   a_reg [INPUT_WIDTH-1:0];
    logic signed [DATA_WIDTH-1:0]   w_reg [NW-1:0];
    logic signed [DATA_WIDTH-1:0]   b_reg [OUTPUT_WIDTH-1:0];
    logic signed [DATA_WIDTH-1:0]   z_buf [OUTPUT_WIDTH-1:0];

    logic [WW_B-1:0]                w_idx;
    logic [JW_B-1:0]                j_next;
    logic signed [PW-1:0]           prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    bias0_ext;
    logic signed [ACC_WIDTH-1:0]    biasn_ext;
    logic signed [ACC_WIDTH-1:0]    shifted;
    logic                           sat_hi;
    logic                           sat_lo;
    logic signed [DATA_WIDTH-1:0]   sat_val;
    logic signed [DATA_WIDTH-1:0]   z_next [OUTPUT_WIDTH-1:0];

    assign w_idx     = WW_B'(j_reg) * WW_B'(INPUT_WIDTH) + WW_B'(i_reg);
    assign j_next    = j_reg + 1'b1;
    assign prod      = PW'(a_reg[i_reg]) * PW'(w_reg[w_idx]);
    assign prod_ext  = ACC_WIDTH'(prod);
    assign bias0_ext = ACC_WIDTH'(b_in[0]) <<< FRAC_BITS;
    assign biasn_ext = ACC_WIDTH'(b_reg[j_next]) <<< FRAC_BITS;

    // Arithmetic shift truncates toward -inf; clamp only at the final narrowing.
    assign shifted = acc_reg >>> FRAC_BITS;
    assign sat_hi  = shifted > ZMAX;
    assign sat_lo  = shifted < ZMIN;
    assign sat_val = sat_hi ? DMAX : (sat_lo ? DMIN : shifted[DATA_WIDTH-1:0]);

    // Buffer image with the current neuron merged in, so z_out is loaded in one shot.
    generate
        for (genvar gi = 0; gi < OUTPUT_WIDTH; gi++) begin : g_znext
            assign z_next[gi] = (j_reg == JW_B'(gi)) ? sat_val : z_buf[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            acc_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            for (int k = 0; k < INPUT_WIDTH; k++)  a_reg[k] <= '0;
            for (int k = 0; k < NW; k++)           w_reg[k] <= '0;
            for (int k = 0; k < OUTPUT_WIDTH; k++) begin
                b_reg[k] <= '0;
                z_buf[k] <= '0;
                z_out[k] <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        w_reg     <= w_in;
                        b_reg     <= b_in;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        acc_reg   <= bias0_ext;
                        busy      <= 1'b1;
                        sat_flag  <= 1'b0;
                        state_reg <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_reg <= acc_reg + prod_ext;
                    if (i_reg == IW_B'(INPUT_WIDTH - 1)) begin
                        state_reg <= S_STORE;
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                S_STORE: begin
                    z_buf <= z_next;
                    if (sat_hi || sat_lo) sat_flag <= 1'b1;
                    i_reg <= '0;
                    if (j_reg != JW_B'(OUTPUT_WIDTH - 1)) begin
                        j_reg     <= j_next;
                        acc_reg   <= biasn_ext;
                        state_reg <= S_MAC;
                    end else begin
                        z_out     <= z_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
